// File: rtl/led_pwm_driver.sv
// LED output stage: latches the PIO pattern and duty at PWM period boundaries, then
// applies PWM brightness, optional blinking and inversion. Avalon-MM slave, 4 words.
module led_pwm_driver #(
  parameter int CLK_DIV = 50,
  parameter int BLINK_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_pattern,
  output logic [7:0]  led_out
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [7:0]         duty_q, duty_d;
  logic [BLINK_W-1:0] blink_half_q, blink_half_d;
  logic               enable_q, enable_d;
  logic               invert_q, invert_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [7:0]         active_pattern_q, active_pattern_d;
  logic [7:0]         active_duty_q, active_duty_d;
  logic [7:0]         led_out_q, led_out_d;

  logic wr, wr_duty, wr_blink, wr_ctrl;
  logic tick, wrap, on;
  logic unused_wd;

  assign wr       = chipselect & ~write_n;
  assign wr_duty  = wr & (address == 2'd0);
  assign wr_blink = wr & (address == 2'd1);
  assign wr_ctrl  = wr & (address == 2'd2);
  assign unused_wd = ^writedata;

  assign tick = enable_q & (pre_cnt_q == PRE_MAX);
  assign wrap = tick & (pwm_cnt_q == 8'hFF);
  // Full duty is a special case so 8'hFF means solid on rather than 255/256.
  assign on   = (active_duty_q == 8'hFF) | (pwm_cnt_q < active_duty_q);

  always_comb begin
    duty_d           = wr_duty  ? writedata[7:0] : duty_q;
    blink_half_d     = wr_blink ? writedata[BLINK_W-1:0] : blink_half_q;
    enable_d         = wr_ctrl  ? writedata[0] : enable_q;
    invert_d         = wr_ctrl  ? writedata[1] : invert_q;
    pre_cnt_d        = pre_cnt_q;
    pwm_cnt_d        = pwm_cnt_q;
    blink_cnt_d      = blink_cnt_q;
    blink_phase_d    = blink_phase_q;
    active_pattern_d = active_pattern_q;
    active_duty_d    = active_duty_q;

    if (!enable_q) begin
      pre_cnt_d        = '0;
      pwm_cnt_d        = '0;
      active_pattern_d = led_pattern;
      active_duty_d    = duty_q;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) pwm_cnt_d = pwm_cnt_q + 8'd1;
      if (wrap) begin
        active_pattern_d = led_pattern;
        active_duty_d    = duty_q;
      end
    end

    // A half-period write restarts the blink sequence even if a wrap lands in the same cycle.
    if (wr_blink || !enable_q || blink_half_q == '0) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (wrap) begin
      if (blink_cnt_q == blink_half_q - BLINK_W'(1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    led_out_d = ({8{on & blink_phase_q & enable_q}} & active_pattern_q) ^ {8{invert_q}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q           <= 8'hFF;
      blink_half_q     <= '0;
      enable_q         <= 1'b1;
      invert_q         <= 1'b0;
      pre_cnt_q        <= '0;
      pwm_cnt_q        <= '0;
      blink_cnt_q      <= '0;
      blink_phase_q    <= 1'b1;
      active_pattern_q <= '0;
      active_duty_q    <= 8'hFF;
      led_out_q        <= '0;
    end else begin
      duty_q           <= duty_d;
      blink_half_q     <= blink_half_d;
      enable_q         <= enable_d;
      invert_q         <= invert_d;
      pre_cnt_q        <= pre_cnt_d;
      pwm_cnt_q        <= pwm_cnt_d;
      blink_cnt_q      <= blink_cnt_d;
      blink_phase_q    <= blink_phase_d;
      active_pattern_q <= active_pattern_d;
      active_duty_q    <= active_duty_d;
      led_out_q        <= led_out_d;
    end
  end

  assign led_out = led_out_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[7:0] = duty_q;
      2'd1: readdata[BLINK_W-1:0] = blink_half_q;
      2'd2: readdata[1:0] = {invert_q, enable_q};
      default: begin
        readdata[0]     = blink_phase_q;
        readdata[15:8]  = pwm_cnt_q;
        readdata[23:16] = active_pattern_q;
      end
    endcase
  end

endmodule
